// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory and its port arbiter.
// DMEM_ARB_RANGE_CHECK_EN (used by dmem_port_arbiter) enables the window check.
package dmem_pkg;

    localparam logic [31:0] MEM_START = 32'h8002_0000;
    localparam int unsigned MEM_DEPTH = 262144;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        byte_acc;
    } dmem_req_t;

endpackage

// File: rtl/dmem_byte_lane.sv
// Big-endian byte lane extraction for memory read data.
// Byte reads are zero-extended into bits [7:0]; word reads pass through.
module dmem_byte_lane (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic        i_byte,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_word;
        if (i_byte) begin
            unique case (i_addr)
                2'b00:   o_data = {24'h0, i_word[31:24]};
                2'b01:   o_data = {24'h0, i_word[23:16]};
                2'b10:   o_data = {24'h0, i_word[15:8]};
                default: o_data = {24'h0, i_word[7:0]};
            endcase
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin two-port arbiter and sequencer for the single-ported data memory.
// Define DMEM_ARB_RANGE_CHECK_EN to reject addresses outside the memory window.
module dmem_port_arbiter #(
    parameter logic [31:0] MEM_START = dmem_pkg::MEM_START,
    parameter int unsigned MEM_DEPTH = dmem_pkg::MEM_DEPTH
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_we,
    input  logic        p0_byte,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_we,
    input  logic        p1_byte,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_access_size,
    output logic        mem_byte_s,
    output logic        mem_read_write,
    output logic        mem_enable,
    input  logic [31:0] mem_data_out
);

    import dmem_pkg::*;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam logic RANGE_CHK = 1'b1;
`else
    localparam logic RANGE_CHK = 1'b0;
`endif

    arb_state_t  r_state;
    logic        r_last;
    logic        r_gnt;
    logic        r_err;
    logic        r_mem_en;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_we;
    logic        r_mem_byte;
    logic [1:0]  r_ack;
    logic [1:0]  r_errs;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_grant;
    dmem_req_t   w_sel;
    logic [31:0] w_off;
    logic        w_in_range;
    logic        w_aligned;
    logic        w_legal;
    logic [31:0] w_fmt;

    // Contention goes to the port that did not win last time.
    always_comb begin
        w_grant = PORT_CPU;
        if (p0_req && p1_req) begin
            w_grant = ~r_last;
        end else if (p1_req) begin
            w_grant = PORT_LDR;
        end
    end

    assign w_sel = (w_grant == PORT_LDR)
                 ? {p1_addr, p1_wdata, p1_we, p1_byte}
                 : {p0_addr, p0_wdata, p0_we, p0_byte};

    assign w_off      = w_sel.addr - MEM_START;
    assign w_in_range = (w_sel.addr >= MEM_START) &&
                        ({2'b00, w_off[31:2]} < MEM_DEPTH);
    assign w_aligned  = w_sel.byte_acc || (w_sel.addr[1:0] == 2'b00);
    assign w_legal    = w_aligned && (!RANGE_CHK || w_in_range);

    dmem_byte_lane u_lane (
        .i_word (mem_data_out),
        .i_addr (r_mem_addr[1:0]),
        .i_byte (r_mem_byte),
        .o_data (w_fmt)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_last      <= PORT_LDR;
            r_gnt       <= PORT_CPU;
            r_err       <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_byte  <= 1'b0;
            r_ack       <= 2'b00;
            r_errs      <= 2'b00;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_ack  <= 2'b00;
                    r_errs <= 2'b00;
                    if (p0_req || p1_req) begin
                        r_gnt       <= w_grant;
                        r_last      <= w_grant;
                        r_err       <= !w_legal;
                        r_mem_en    <= w_legal;
                        r_mem_addr  <= w_legal ? w_sel.addr : '0;
                        r_mem_wdata <= w_legal ? w_sel.wdata : '0;
                        r_mem_we    <= w_legal && w_sel.we;
                        r_mem_byte  <= w_legal && w_sel.byte_acc;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_mem_en    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_mem_we    <= 1'b0;
                    r_mem_byte  <= 1'b0;
                    if (r_mem_en && !r_mem_we) begin
                        if (r_gnt == PORT_LDR) begin
                            r_rdata1 <= w_fmt;
                        end else begin
                            r_rdata0 <= w_fmt;
                        end
                    end
                    r_ack[r_gnt]  <= 1'b1;
                    r_errs[r_gnt] <= r_err;
                    r_state       <= RESP;
                end
                RESP: begin
                    r_ack   <= 2'b00;
                    r_errs  <= 2'b00;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign p0_ack   = r_ack[0];
    assign p1_ack   = r_ack[1];
    assign p0_err   = r_errs[0];
    assign p1_err   = r_errs[1];
    assign p0_rdata = r_rdata0;
    assign p1_rdata = r_rdata1;

    assign mem_enable      = r_mem_en;
    assign mem_address     = r_mem_addr;
    assign mem_data_in     = r_mem_wdata;
    assign mem_read_write  = r_mem_we;
    assign mem_access_size = r_mem_byte;
    assign mem_byte_s      = r_mem_byte;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a small big-endian memory model.
// Define DMEM_ARB_RANGE_CHECK_EN to build both bench and design with range checks.
module tb_dmem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        p0_req = 1'b0;
    logic [31:0] p0_addr = '0;
    logic [31:0] p0_wdata = '0;
    logic        p0_we = 1'b0;
    logic        p0_byte = 1'b0;
    logic        p0_ack;
    logic        p0_err;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0;
    logic [31:0] p1_addr = '0;
    logic [31:0] p1_wdata = '0;
    logic        p1_we = 1'b0;
    logic        p1_byte = 1'b0;
    logic        p1_ack;
    logic        p1_err;
    logic [31:0] p1_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_access_size;
    logic        mem_byte_s;
    logic        mem_read_write;
    logic        mem_enable;
    logic [31:0] mem_data_out;

    dmem_port_arbiter dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .p0_req          (p0_req),
        .p0_addr         (p0_addr),
        .p0_wdata        (p0_wdata),
        .p0_we           (p0_we),
        .p0_byte         (p0_byte),
        .p0_ack          (p0_ack),
        .p0_err          (p0_err),
        .p0_rdata        (p0_rdata),
        .p1_req          (p1_req),
        .p1_addr         (p1_addr),
        .p1_wdata        (p1_wdata),
        .p1_we           (p1_we),
        .p1_byte         (p1_byte),
        .p1_ack          (p1_ack),
        .p1_err          (p1_err),
        .p1_rdata        (p1_rdata),
        .mem_address     (mem_address),
        .mem_data_in     (mem_data_in),
        .mem_access_size (mem_access_size),
        .mem_byte_s      (mem_byte_s),
        .mem_read_write  (mem_read_write),
        .mem_enable      (mem_enable),
        .mem_data_out    (mem_data_out)
    );

    always #5 clock = ~clock;

    // Memory model: 256 words, big-endian byte lanes.
    logic [31:0] tb_mem [256] = '{default: 32'h0};

    assign mem_data_out = mem_enable ? tb_mem[mem_address[9:2]] : 32'h0;

    always @(posedge clock) begin
        if (mem_enable && mem_read_write) begin
            if (mem_access_size) begin
                case (mem_address[1:0])
                    2'b00: tb_mem[mem_address[9:2]][31:24] <= mem_data_in[7:0];
                    2'b01: tb_mem[mem_address[9:2]][23:16] <= mem_data_in[7:0];
                    2'b10: tb_mem[mem_address[9:2]][15:8]  <= mem_data_in[7:0];
                    default: tb_mem[mem_address[9:2]][7:0] <= mem_data_in[7:0];
                endcase
            end else begin
                tb_mem[mem_address[9:2]] <= mem_data_in;
            end
        end
    end

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_acks = 0;
    int   en_cnt = 0;
    exp_t e;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mem_enable) en_cnt++;
        if (p0_ack || p1_ack) begin
            n_acks++;
            chk("one_ack", 32'(p0_ack & p1_ack), 32'h0);
            if (sb.size() == 0) begin
                chk("unexp_ack", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", 32'(p1_ack), 32'(e.port));
                chk("ack_err", 32'(p1_ack ? p1_err : p0_err), 32'(e.err));
                chk("ack_rdata", p1_ack ? p1_rdata : p0_rdata, e.rdata);
            end
        end
    end

    task automatic drive(input bit port, input logic req, input logic [31:0] addr,
                         input logic [31:0] wd, input logic we, input logic bt);
        if (port) begin
            p1_req = req; p1_addr = addr; p1_wdata = wd;
            p1_we = we; p1_byte = bt;
        end else begin
            p0_req = req; p0_addr = addr; p0_wdata = wd;
            p0_we = we; p0_byte = bt;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic do_txn(input bit port, input logic [31:0] addr,
                          input logic [31:0] wd, input logic we, input logic bt,
                          input bit x_err, input logic [31:0] x_rd, input bit x_en);
        int base;
        exp_t it;
        it.port = port; it.err = x_err; it.rdata = x_rd;
        sb.push_back(it);
        @(posedge clock);
        #1 drive(port, 1'b1, addr, wd, we, bt);
        base = en_cnt;
        @(posedge clock);
        #1;
        chk("access_en", 32'(mem_enable), 32'(x_en));
        chk("early_ack", 32'(p0_ack | p1_ack), 32'h0);
        if (x_en) begin
            chk("mem_addr", mem_address, addr);
            chk("mem_rw", 32'(mem_read_write), 32'(we));
            chk("mem_size", 32'({mem_access_size, mem_byte_s}), 32'({bt, bt}));
        end
        @(posedge clock);
        #1;
        chk("ack_lat2", 32'(port ? p1_ack : p0_ack), 32'h1);
        drive(port, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        chk("en_cycles", 32'(en_cnt - base), 32'(x_en));
    endtask

    initial begin
        do_reset();
        chk("rst_acks", 32'({p0_ack, p1_ack, p0_err, p1_err}), 32'h0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);
        chk("rst_mem", 32'({mem_enable, mem_read_write, mem_access_size}), 32'h0);

        do_txn(1'b0, 32'h8002_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        do_txn(1'b0, 32'h8002_0010, 32'h0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        do_txn(1'b1, 32'h8002_0021, 32'h0000_00A5, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        do_txn(1'b1, 32'h8002_0020, 32'h0, 1'b0, 1'b0, 1'b0, 32'h00A5_0000, 1'b1);
        do_txn(1'b1, 32'h8002_0021, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_00A5, 1'b1);
        do_txn(1'b0, 32'h8002_0002, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        do_txn(1'b0, 32'h8002_0013, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_00EF, 1'b1);
`ifdef DMEM_ARB_RANGE_CHECK_EN
        do_txn(1'b0, 32'h8001_FFFC, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_00EF, 1'b0);
`else
        do_txn(1'b0, 32'h8001_FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
`endif

        // Both ports hold requests: grants must alternate starting with port 0.
        do_reset();
        begin
            int base;
            exp_t it;
            for (int i = 0; i < 4; i++) begin
                it.port = i[0];
                it.err = 1'b0;
                it.rdata = i[0] ? 32'h00A5_0000 : 32'hDEAD_BEEF;
                sb.push_back(it);
            end
            base = n_acks;
            @(posedge clock);
            #1;
            drive(1'b0, 1'b1, 32'h8002_0010, 32'h0, 1'b0, 1'b0);
            drive(1'b1, 1'b1, 32'h8002_0020, 32'h0, 1'b0, 1'b0);
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                #1;
                if (n_acks - base >= 4) break;
            end
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            chk("rr_acks", 32'(n_acks - base), 32'h4);
        end

        // Reset while a port 0 read is in ACCESS aborts it silently.
        repeat (3) @(posedge clock);
        #1 drive(1'b0, 1'b1, 32'h8002_0010, 32'h0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        chk("abort_en", 32'(mem_enable), 32'h1);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_acks", 32'({p0_ack, p1_ack, p0_err, p1_err}), 32'h0);
        chk("abort_mem", 32'({mem_enable, mem_read_write, mem_byte_s}), 32'h0);
        chk("abort_addr", mem_address | mem_data_in, 32'h0);
        chk("abort_rdata", p0_rdata | p1_rdata, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        do_txn(1'b0, 32'h8002_0010, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_00DE, 1'b1);

        repeat (3) @(posedge clock);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported data memory.
- Port 0 is the CPU load/store path; port 1 is the program/debug loader.
- Grants one access at a time using round-robin arbitration.
- Drives the memory's enable, read/write, size and address signals; performs byte-lane extraction on reads; returns registered read data with an ack pulse.

Parameters:
- MEM_START, 32'h8002_0000, base byte address of the data memory window.
- MEM_DEPTH, 262144, memory depth in 32-bit words.

Ports:
- clock  in  1  sole clock; all state changes on its rising edge
- reset_n  in  1  synchronous, active-low reset
- p0_req  in  1  port 0 request; held high until p0_ack
- p0_addr  in  32  port 0 byte address
- p0_wdata  in  32  port 0 write data (byte writes use [7:0])
- p0_we  in  1  1 = write, 0 = read
- p0_byte  in  1  1 = byte access, 0 = word access
- p0_ack  out  1  one-cycle completion pulse
- p0_err  out  1  qualifies p0_ack; 1 = access rejected
- p0_rdata  out  32  read result, valid while p0_ack is high
- p1_req, p1_addr, p1_wdata, p1_we, p1_byte, p1_ack, p1_err, p1_rdata: identical to port 0
- mem_address  out  32  to memory address
- mem_data_in  out  32  to memory data_in
- mem_access_size  out  1  1 = byte access
- mem_byte_s  out  1  driven equal to mem_access_size
- mem_read_write  out  1  1 = write
- mem_enable  out  1  memory enable
- mem_data_out  in  32  memory read data; combinational while enabled

Behaviour:
- **Reset:** applies when reset_n = 0 at a clock edge.
  - State = IDLE, last_grant = 1 (so port 0 wins first).
  - All acks, errs and mem_* outputs = 0; rdata registers = 0.
  - Reset during ACCESS or RESP aborts the access: no ack is issued and a write in flight may be dropped.
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - If neither port requests, remain in IDLE.
  - If exactly one port requests, grant it.
  - If both request, grant the port not equal to last_grant, then set last_grant to the granted port.
  - Latch the granted port's addr, wdata, we and byte into request registers, then go to ACCESS.
- **ACCESS (exactly 1 cycle):**
  - If the latched request is legal: mem_enable = 1, mem_address = latched addr, mem_read_write = latched we, mem_access_size = mem_byte_s = latched byte, mem_data_in = latched wdata.
  - On reads, capture mem_data_out at the end of the cycle into the granted port's rdata register.
  - If the latched request is illegal: mem_enable stays 0 and the error flag is set.
  - Go to RESP.
- **RESP:**
  - Granted port's ack = 1 for exactly one cycle; err = error flag.
  - Go to IDLE.
- **Read data formatting:**
  - Word read: rdata = mem_data_out.
  - Byte read (big-endian lanes): addr[1:0] = 00 selects [31:24], 01 selects [23:16], 10 selects [15:8], 11 selects [7:0].
  - The selected byte is zero-extended into rdata[7:0].
- **Writes:** rdata is left unchanged. The write commits at the clock edge ending ACCESS.
- **Illegal requests:** a word access with addr[1:0] != 0 (misaligned). The memory is not enabled and rdata is unchanged.
- **Latency and throughput:**
  - Request sampled in IDLE at cycle N; mem_enable high in cycle N+1; ack high in cycle N+2.
  - Maximum throughput is one access per 3 cycles.
- **Handshake rules:**
  - A requester must deassert req in the cycle after ack, or it is treated as a new request at the next IDLE.
  - Dropping req while granted does not cancel the access.
  - Changing a port's request fields mid-grant has no effect; they were latched in IDLE.
- **Starvation:** with both ports requesting continuously, grants alternate 0, 1, 0, 1, …
- **mem_* outputs:** all 0 outside ACCESS, so the memory never sees enable outside a legal access.

Optional Feature:
- Macro: DMEM_ARB_RANGE_CHECK_EN.
- When defined, a request is also illegal if addr < MEM_START or (addr − MEM_START) >> 2 ≥ MEM_DEPTH. Such requests complete with err = 1 and no memory enable.
- When undefined, no range check is performed and every aligned access reaches the memory.

Decomposition:
- Shared package `dmem_pkg` holds:
  - MEM_START and MEM_DEPTH defaults (the data memory uses the same values);
  - the FSM state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - the port-ID constants PORT_CPU = 0 and PORT_LDR = 1.
- One natural sub-module: `dmem_byte_lane`, a combinational block taking word, addr[1:0] and byte, and producing the formatted rdata. It is reused later for the load path.

Test Plan:
- Port 0 word write of 32'hDEADBEEF to 32'h8002_0010, then word read of the same address → write ack at cycle +2 with err = 0; read ack with p0_rdata = 32'hDEADBEEF.
- Port 1 byte write of 8'hA5 to 32'h8002_0021, then word read of 32'h8002_0020 → bits [23:16] = 8'hA5; byte read of 32'h8002_0021 → p1_rdata = 32'h0000_00A5.
- Both ports hold req for 4 transactions from reset → grant order 0, 1, 0, 1; no cycle has both acks high.
- Port 0 word read of 32'h8002_0002 (misaligned) → mem_enable never asserts; p0_ack = 1 with p0_err = 1; p0_rdata unchanged.
- reset_n driven low during ACCESS of a port 0 request → no p0_ack; all outputs 0 the next cycle; a new request after reset completes normally.
- With DMEM_ARB_RANGE_CHECK_EN defined, a read of 32'h8001_FFFC → err = 1, no mem_enable. With the macro undefined, the same read → mem_enable = 1 and err = 0.
